// File: rtl/memory_byte_sequencer.sv
// Byte-serial sequencer between a DATA_WIDTH word and an 8-bit memory, little-endian.
// Define MEMORY_BYTE_SEQUENCER_SIGN_EXT_EN to sign-extend short reads (default: zero-extend).
module memory_byte_sequencer #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 16,
    localparam int BYTES      = DATA_WIDTH / 8,
    localparam int LEN_W      = $clog2(BYTES)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Write,
    input  logic [LEN_W-1:0]      Len,
    input  logic [ADDR_WIDTH-1:0] BaseAddr,
    input  logic [DATA_WIDTH-1:0] WData,
    input  logic [7:0]            MemOut,
    output logic [ADDR_WIDTH-1:0] Mem_Address,
    output logic [7:0]            Mem_Data,
    output logic                  Mem_WR,
    output logic                  Mem_CS,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] RData,
    output logic [1:0]            dbg_state
);

    // Handshake: Start is sampled only in IDLE; Busy covers XFER and DONE;
    // Done is a single-cycle pulse coinciding with RData becoming valid.
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        k_q, k_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              mem_data_q, mem_data_d;
    logic                    mem_wr_q, mem_wr_d;
    logic                    mem_cs_q, mem_cs_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Bytes above len are overwritten with the fill byte.
    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] raw,
                                                     input logic [LEN_W-1:0] last);
        logic [DATA_WIDTH-1:0] res;
        logic [7:0]            fill;
        res  = raw;
        fill = 8'h00;
`ifdef MEMORY_BYTE_SEQUENCER_SIGN_EXT_EN
        for (int i = 0; i < BYTES; i++) begin
            if (i == int'(last)) fill = {8{raw[8*i+7]}};
        end
`endif
        for (int i = 0; i < BYTES; i++) begin
            if (i > int'(last)) res[8*i +: 8] = fill;
        end
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        len_d      = len_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        shadow_d   = shadow_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        mem_data_d = 8'h00;
        mem_wr_d   = 1'b0;
        mem_cs_d   = 1'b1;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d  = XFER;
                    write_d  = Write;
                    len_d    = Len;
                    wdata_d  = WData;
                    k_d      = '0;
                    shadow_d = '0;
                    addr_d   = BaseAddr;
                    mem_cs_d = 1'b0;
                    mem_wr_d = Write;
                    busy_d   = 1'b1;
                    if (Write) mem_data_d = WData[7:0];
                end
            end
            XFER: begin
                busy_d = 1'b1;
                if (!write_q) shadow_d[{k_q, 3'b000} +: 8] = MemOut;
                if (k_q == len_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (!write_q) rdata_d = extend(shadow_d, len_q);
                end else begin
                    // Address increments modulo 2^ADDR_WIDTH by natural wrap.
                    k_d      = k_q + LEN_W'(1);
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    mem_cs_d = 1'b0;
                    mem_wr_d = write_q;
                    if (write_q) mem_data_d = wdata_q[{k_d, 3'b000} +: 8];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            len_q      <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            shadow_q   <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            mem_data_q <= 8'h00;
            mem_wr_q   <= 1'b0;
            mem_cs_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            len_q      <= len_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            shadow_q   <= shadow_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            mem_data_q <= mem_data_d;
            mem_wr_q   <= mem_wr_d;
            mem_cs_q   <= mem_cs_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Mem_Address = addr_q;
    assign Mem_Data    = mem_data_q;
    assign Mem_WR      = mem_wr_q;
    assign Mem_CS      = mem_cs_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign RData       = rdata_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_memory_byte_sequencer.sv
// Randomized bench for memory_byte_sequencer against a byte-array memory model.
// Sign-extension expectations follow MEMORY_BYTE_SEQUENCER_SIGN_EXT_EN.
module tb_memory_byte_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, wr_i;
    logic [1:0]  len_i;
    logic [15:0] base_i;
    logic [31:0] wdata_i;
    logic [7:0]  mem_out;
    logic [15:0] mem_address;
    logic [7:0]  mem_data;
    logic        mem_wr, mem_cs, busy, done;
    logic [31:0] rdata;
    logic [1:0]  dbg_state;

    logic        start64;
    logic [2:0]  len64;
    logic [15:0] base64;
    logic [7:0]  mem_out64;
    logic [15:0] mem_address64;
    logic [7:0]  mem_data64;
    logic        mem_wr64, mem_cs64, busy64, done64;
    logic [63:0] rdata64;
    logic [1:0]  dbg_state64;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [24:0] exp_q[$];
    logic [31:0] rdata_exp;
    int          n_tests = 0;
    int          n_fail  = 0;

    memory_byte_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .Clock(clk), .Reset(reset), .Start(start), .Write(wr_i), .Len(len_i),
        .BaseAddr(base_i), .WData(wdata_i), .MemOut(mem_out),
        .Mem_Address(mem_address), .Mem_Data(mem_data), .Mem_WR(mem_wr),
        .Mem_CS(mem_cs), .Busy(busy), .Done(done), .RData(rdata), .dbg_state(dbg_state)
    );

    memory_byte_sequencer #(.DATA_WIDTH(64), .ADDR_WIDTH(16)) dut64 (
        .Clock(clk), .Reset(reset), .Start(start64), .Write(1'b0), .Len(len64),
        .BaseAddr(base64), .WData(64'h0), .MemOut(mem_out64),
        .Mem_Address(mem_address64), .Mem_Data(mem_data64), .Mem_WR(mem_wr64),
        .Mem_CS(mem_cs64), .Busy(busy64), .Done(done64), .RData(rdata64), .dbg_state(dbg_state64)
    );

    assign mem_out   = mem[mem_address];
    assign mem_out64 = mem_address64[7:0] + 8'd1;

    always @(posedge clk) begin
        if (!mem_cs && mem_wr) mem[mem_address] = mem_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [15:0] base, input int len);
        logic [31:0] v;
        logic [7:0]  fill;
        v = 32'h0;
        for (int k = 0; k <= len; k++) v = v | (32'(ref_mem[16'(base + 16'(k))]) << (8 * k));
        fill = 8'h00;
`ifdef MEMORY_BYTE_SEQUENCER_SIGN_EXT_EN
        if (ref_mem[16'(base + 16'(len))][7]) fill = 8'hFF;
`endif
        for (int k = len + 1; k < 4; k++) v = v | (32'(fill) << (8 * k));
        return v;
    endfunction

    task automatic run_xfer(input bit wr, input int len, input logic [15:0] base,
                            input logic [31:0] wd, input bit poke);
        logic [24:0] e;
        logic [15:0] a;
        for (int k = 0; k <= len; k++) begin
            a = 16'(base + 16'(k));
            e = {wr, a, (wr ? wd[8*k +: 8] : 8'h00)};
            exp_q.push_back(e);
        end
        if (!wr) rdata_exp = model_read(base, len);
        @(negedge clk);
        start = 1'b1; wr_i = wr; len_i = 2'(len); base_i = base; wdata_i = wd;
        @(posedge clk); #1;
        start = 1'b0; wr_i = ~wr; len_i = 2'($urandom); base_i = 16'($urandom); wdata_i = $urandom;
        for (int k = 0; k <= len; k++) begin
            e = exp_q.pop_front();
            check("cs", 64'(mem_cs), 64'(1'b0));
            check("addr", 64'(mem_address), 64'(e[23:8]));
            check("wr", 64'(mem_wr), 64'(e[24]));
            check("data", 64'(mem_data), 64'(e[7:0]));
            check("busy", 64'(busy), 64'(1'b1));
            check("done_early", 64'(done), 64'(1'b0));
            if (poke && k == 1) begin
                start = 1'b1; base_i = ~base; len_i = ~2'(len); wr_i = ~wr;
            end
            @(posedge clk); #1;
            if (wr) begin
                a = e[23:8];
                ref_mem[a] = e[7:0];
                check("mem", 64'(mem[a]), 64'(ref_mem[a]));
            end
        end
        check("done", 64'(done), 64'(1'b1));
        check("busy_done", 64'(busy), 64'(1'b1));
        check("cs_done", 64'(mem_cs), 64'(1'b1));
        check("wr_done", 64'(mem_wr), 64'(1'b0));
        check("data_done", 64'(mem_data), 64'h0);
        check("addr_hold", 64'(mem_address), 64'(16'(base + 16'(len))));
        check("rdata", 64'(rdata), 64'(rdata_exp));
        @(posedge clk); #1;
        start = 1'b0;
        check("done_pulse", 64'(done), 64'(1'b0));
        check("busy_idle", 64'(busy), 64'(1'b0));
        check("rdata_hold", 64'(rdata), 64'(rdata_exp));
        if (poke) begin
            @(posedge clk); #1;
            check("no_requeue", 64'(busy), 64'(1'b0));
            check("no_requeue_cs", 64'(mem_cs), 64'(1'b1));
        end
    endtask

    initial begin
        logic [15:0] b;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        reset = 1'b1; start = 1'b1; wr_i = 1'b1; len_i = 2'd3; base_i = 16'h1234; wdata_i = 32'hFFFF_FFFF;
        start64 = 1'b1; len64 = 3'd7; base64 = 16'h0;
        rdata_exp = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_done", 64'(done), 64'(1'b0));
        check("rst_cs", 64'(mem_cs), 64'(1'b1));
        check("rst_wr", 64'(mem_wr), 64'(1'b0));
        check("rst_data", 64'(mem_data), 64'h0);
        check("rst_addr", 64'(mem_address), 64'h0);
        check("rst_rdata", 64'(rdata), 64'h0);
        check("rst_busy64", 64'(busy64), 64'(1'b0));
        reset = 1'b0; start = 1'b0; start64 = 1'b0;

        // Directed: write word to 0x0100
        run_xfer(1'b1, 3, 16'h0100, 32'hA1B2C3D4, 1'b0);
        check("s042", {32'h0, mem[16'h0103], mem[16'h0102], mem[16'h0101], mem[16'h0100]}, 64'hA1B2C3D4);

        // Directed: two-byte read with negative top byte
        mem[16'h0200] = 8'h34; ref_mem[16'h0200] = 8'h34;
        mem[16'h0201] = 8'h92; ref_mem[16'h0201] = 8'h92;
        run_xfer(1'b0, 1, 16'h0200, 32'h0, 1'b0);
`ifdef MEMORY_BYTE_SEQUENCER_SIGN_EXT_EN
        check("s043", 64'(rdata), 64'hFFFF9234);
`else
        check("s043", 64'(rdata), 64'h00009234);
`endif

        // Directed: address wrap and ignored Start during XFER/DONE
        run_xfer(1'b1, 3, 16'hFFFE, 32'h55AA_1234, 1'b0);
        check("s044", {32'h0, mem[16'h0001], mem[16'h0000], mem[16'hFFFF], mem[16'hFFFE]}, 64'h55AA1234);
        run_xfer(1'b1, 3, 16'h0300, 32'hCAFE_F00D, 1'b1);
        run_xfer(1'b0, 2, 16'h0300, 32'h0, 1'b1);

        // Reset during byte 2 of a 4-byte read
        @(negedge clk);
        start = 1'b1; wr_i = 1'b0; len_i = 2'd3; base_i = 16'h0400;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_addr", 64'(mem_address), 64'h0402);
        reset = 1'b1;
        @(posedge clk); #1;
        rdata_exp = 32'h0;
        check("abort_busy", 64'(busy), 64'(1'b0));
        check("abort_cs", 64'(mem_cs), 64'(1'b1));
        check("abort_rdata", 64'(rdata), 64'h0);
        check("abort_done", 64'(done), 64'(1'b0));
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_no_done", 64'(done), 64'(1'b0));
        run_xfer(1'b0, 3, 16'h0400, 32'h0, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 24; t++) begin
            int l;
            bit w;
            w = 1'($urandom_range(0, 1));
            l = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) b = 16'hFFFC + 16'($urandom_range(0, 3));
            else b = 16'($urandom_range(0, 65535));
            run_xfer(w, l, b, $urandom, (l >= 1) && ($urandom_range(0, 2) == 0));
        end

        // 64-bit build: eight-byte read
        @(negedge clk);
        start64 = 1'b1; len64 = 3'd7; base64 = 16'h0000;
        @(posedge clk); #1;
        start64 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check("w64_addr", 64'(mem_address64), 64'(c - 1));
            check("w64_done_early", 64'(done64), 64'(1'b0));
            @(posedge clk); #1;
        end
        check("w64_done", 64'(done64), 64'(1'b1));
        check("w64_rdata", rdata64, 64'h0807060504030201);
        @(posedge clk); #1;
        check("w64_done_pulse", 64'(done64), 64'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_byte_sequencer.md
MEMORY_BYTE_SEQUENCER -- requirements
Module: memory_byte_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; legal values 16, 32, 64; BYTES = DATA_WIDTH/8.
REQ-002 Parameter ADDR_WIDTH, default 16, memory address width in bits.
REQ-003 Derived LEN_W = log2(BYTES), width of the Len port.
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-005 Clock  in  1  rising-edge clock.
REQ-006 Reset  in  1  synchronous active-high reset.
REQ-007 Start  in  1  request a transfer; sampled only in IDLE.
REQ-008 Write  in  1  1 = word-to-memory write, 0 = memory-to-word read; latched at Start.
REQ-009 Len  in  LEN_W  byte count minus 1; latched at Start.
REQ-010 BaseAddr  in  ADDR_WIDTH  address of byte 0; latched at Start.
REQ-011 WData  in  DATA_WIDTH  write word; latched at Start.
REQ-012 MemOut  in  8  memory read byte, combinational from Mem_Address.
REQ-013 Mem_Address  out  ADDR_WIDTH  byte address.
REQ-014 Mem_Data  out  8  byte to memory.
REQ-015 Mem_WR  out  1  1 = write.
REQ-016 Mem_CS  out  1  active-low chip select.
REQ-017 Busy  out  1  high in XFER and DONE.
REQ-018 Done  out  1  one-cycle completion pulse.
REQ-019 RData  out  DATA_WIDTH  assembled read word.

Function
REQ-020 The FSM SHALL have three states: IDLE, XFER and DONE.
REQ-021 IDLE with Start=1 at an edge SHALL latch Write, Len, BaseAddr and WData, clear the byte index k, and go to XFER.
REQ-022 XFER SHALL move one byte per cycle for k = 0..Len, taking Len+1 cycles, then go to DONE.
REQ-023 DONE SHALL last exactly one cycle with Done=1, then return to IDLE.
REQ-024 Start at edge n SHALL place byte k in cycle n+1+k and raise Done in cycle n+Len+2.
REQ-025 In XFER, Mem_Address SHALL equal (BaseAddr+k) mod 2^ADDR_WIDTH, wrapping silently.
REQ-026 Mem_CS SHALL be 0 only in XFER.
REQ-027 Mem_WR SHALL be 1 only in a write XFER.
REQ-028 Mem_Data SHALL be 0 outside a write XFER.
REQ-029 Byte order SHALL be little-endian: byte k maps to word bits [8k+7:8k].
REQ-030 A write SHALL drive Mem_Data = WData[8k+7:8k].
REQ-031 A read SHALL capture MemOut into a shadow register at the clock edge ending cycle k.
REQ-032 At the start of DONE, RData SHALL take the shadow value, with bytes above Len filled per REQ-040/041.
REQ-033 RData SHALL hold between reads and SHALL NOT change on writes.
REQ-034 Start SHALL be ignored in XFER and DONE: no queueing and no parameter change.
REQ-035 Outside XFER, Mem_Address SHALL hold its last value.

Reset
REQ-036 Reset SHALL force IDLE, k=0, Busy=0, Done=0, Mem_CS=1, Mem_WR=0, Mem_Data=0, Mem_Address=0 and RData=0.
REQ-037 Reset SHALL take priority over Start.
REQ-038 Reset mid-transfer SHALL abort the transfer, discard partial read data and produce no Done pulse.
REQ-039 The first Start SHALL be accepted at the first edge after Reset deasserts.

Configuration
REQ-040 With macro MEMORY_BYTE_SEQUENCER_SIGN_EXT_EN defined, read bytes above Len SHALL replicate bit 7 of byte Len (sign extension).
REQ-041 With the macro undefined, read bytes above Len SHALL be zero (zero extension); write behaviour SHALL be identical in both builds.

Verification
REQ-042 Scenario: write WData=0xA1B2C3D4, Len=3, BaseAddr=0x0100, Start at edge 0 -> memory bytes D4,C3,B2,A1 at 0x0100..0x0103 in cycles 1..4; Done=1 in cycle 5 only.
REQ-043 Scenario: read Len=1 at 0x0200 holding 0x34,0x92 -> RData=0xFFFF9234 with SIGN_EXT_EN, 0x00009234 without; Done in cycle 3.
REQ-044 Scenario: write Len=3, BaseAddr=0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order.
REQ-045 Scenario: Start pulsed with new parameters during XFER and during DONE -> ignored; exactly one transfer, one Done pulse and unchanged memory targets.
REQ-046 Scenario: Reset at byte 2 of a Len=3 read -> next cycle IDLE, Mem_CS=1, RData=0, no Done; a following Start runs normally.
REQ-047 Scenario: DATA_WIDTH=64, Len=7 read of bytes 0x01..0x08 -> RData=0x0807060504030201, Done in cycle 9.
